// File: rtl/mc_bridge_pkg.sv
// ---------------------------------------------------------------------------
// mc_bridge_pkg
// Shared definitions for the MCU parallel-bus to SPI/PWM bridge:
//   - register address map
//   - STATUS register bit positions
//   - bus FSM state encoding and register-select enum
//   - helper that packs the STATUS word
// ---------------------------------------------------------------------------
package mc_bridge_pkg;

  // Register address map
  localparam logic [7:0] ADDR_DATA    = 8'h00;
  localparam logic [7:0] ADDR_STATUS  = 8'h01;
  localparam logic [7:0] ADDR_CTRL    = 8'h02;
  localparam logic [7:0] ADDR_IRQEN   = 8'h03;
  localparam logic [7:0] ADDR_PWM_ON  = 8'h19;
  localparam logic [7:0] ADDR_PWM_OFF = 8'h1A;

  // STATUS bit positions
  localparam int STAT_TX_FULL   = 0;
  localparam int STAT_RX_NEMPTY = 1;
  localparam int STAT_SPI_BUSY  = 2;
  localparam int STAT_TX_OVF    = 3;
  localparam int STAT_RX_UNF    = 4;
  localparam int STAT_PROTO_ERR = 5;

  // CTRL = {autocs, cspol, cpha, cpol}; the power-up mode is cpha=1, cspol=1
  localparam logic [3:0] CTRL_RESET = 4'b0110;

  // Bus transaction FSM
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } state_e;

  // Decoded register select
  typedef enum logic [2:0] {
    SEL_DATA,
    SEL_STATUS,
    SEL_CTRL,
    SEL_IRQEN,
    SEL_PWM_ON,
    SEL_PWM_OFF,
    SEL_NONE
  } reg_sel_e;

  // Assemble the STATUS read value from live inputs and sticky flags
  function automatic logic [15:0] packStatus(input logic txFull,
                                             input logic rxNempty,
                                             input logic spiBusy,
                                             input logic txOvf,
                                             input logic rxUnf,
                                             input logic protoErr);
    logic [15:0] s;
    s                 = '0;
    s[STAT_TX_FULL]   = txFull;
    s[STAT_RX_NEMPTY] = rxNempty;
    s[STAT_SPI_BUSY]  = spiBusy;
    s[STAT_TX_OVF]    = txOvf;
    s[STAT_RX_UNF]    = rxUnf;
    s[STAT_PROTO_ERR] = protoErr;
    return s;
  endfunction

endpackage

// File: rtl/mc_sync.sv
// ---------------------------------------------------------------------------
// mc_sync
// STAGES-deep flop chain that brings one asynchronous active-low bus strobe
// into the clock domain. All stages reset to 1 (strobe inactive).
// Ports:
//   clock  in   system clock
//   reset  in   synchronous, active-low reset
//   d_i    in   asynchronous strobe from the pad
//   q_o    out  synchronized strobe
// ---------------------------------------------------------------------------
module mc_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] chain_q;

  // Shift chain, written as a loop so that STAGES=1 is also legal
  always_ff @(posedge clock) begin
    if (!reset) begin
      chain_q <= '1;
    end else begin
      chain_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        chain_q[i] <= chain_q[i-1];
      end
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/mc_bridge.sv
// ---------------------------------------------------------------------------
// mc_bridge
// Bridges an asynchronous MCU parallel bus (active-low CE/OE/WE) onto a
// register file driving SPI FIFO strobes, SPI configuration and AUX PWM
// periods.
// Ports:
//   clock, reset               system clock, synchronous active-low reset
//   mc_ce, mc_oe, mc_we        bus strobes (active-low, asynchronous)
//   mc_add, mc_din             bus address and write data
//   mc_dout, mc_doe            bus read data and pad output enable
//   tx_push, tx_data, tx_full  SPI input FIFO push interface
//   rx_pop, rx_data, rx_nempty SPI output FIFO pop interface
//   spi_busy                   SPI master busy
//   cfg_cpol/cpha/cspol/autocs SPI configuration
//   pwm_on, pwm_off            AUX PWM periods
//   irq                        interrupt request (active-high)
// Build option:
//   MC_BRIDGE_IRQ_EN  adds the IRQEN register at 0x03 and a registered irq.
//                     When undefined, irq is 0 and 0x03 reads as 0.
// ---------------------------------------------------------------------------
module mc_bridge #(
  parameter int MC_DATA_WIDTH = 16,
  parameter int MC_ADD_WIDTH  = 6,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     mc_ce,
  input  logic                     mc_oe,
  input  logic                     mc_we,
  input  logic [MC_ADD_WIDTH-1:0]  mc_add,
  input  logic [MC_DATA_WIDTH-1:0] mc_din,
  output logic [MC_DATA_WIDTH-1:0] mc_dout,
  output logic                     mc_doe,
  output logic                     tx_push,
  output logic [15:0]              tx_data,
  input  logic                     tx_full,
  output logic                     rx_pop,
  input  logic [15:0]              rx_data,
  input  logic                     rx_nempty,
  input  logic                     spi_busy,
  output logic                     cfg_cpol,
  output logic                     cfg_cpha,
  output logic                     cfg_cspol,
  output logic                     cfg_autocs,
  output logic [15:0]              pwm_on,
  output logic [15:0]              pwm_off,
  output logic                     irq
);

  import mc_bridge_pkg::*;

  logic ceSync, oeSync, weSync;

  state_e state_q, state_d;
  logic   commitWr, enterRd, exitRd, protoErrEvt;

  reg_sel_e    sel;
  logic [15:0] wrData;
  logic [15:0] rdValue;

  logic txOvf_q, txOvf_d;
  logic rxUnf_q, rxUnf_d;
  logic protoErr_q, protoErr_d;

  logic                     txPush_q;
  logic [15:0]              txData_q;
  logic                     rxPop_q;
  logic                     popPending_q;
  logic                     doe_q;
  logic [MC_DATA_WIDTH-1:0] dout_q;
  logic [3:0]               ctrl_q;
  logic [15:0]              pwmOn_q;
  logic [15:0]              pwmOff_q;

`ifdef MC_BRIDGE_IRQ_EN
  logic [2:0] irqEn_q;
  logic       irq_q;
`endif

  mc_sync #(.STAGES(SYNC_STAGES)) uSyncCe (.clock(clock), .reset(reset), .d_i(mc_ce), .q_o(ceSync));
  mc_sync #(.STAGES(SYNC_STAGES)) uSyncOe (.clock(clock), .reset(reset), .d_i(mc_oe), .q_o(oeSync));
  mc_sync #(.STAGES(SYNC_STAGES)) uSyncWe (.clock(clock), .reset(reset), .d_i(mc_we), .q_o(weSync));

  // Address and data are taken straight from the pads: the MCU keeps them
  // stable for longer than the strobe synchronizer delay.
  function automatic reg_sel_e decodeAddr(input logic [MC_ADD_WIDTH-1:0] a);
    if      (a == MC_ADD_WIDTH'(ADDR_DATA))    return SEL_DATA;
    else if (a == MC_ADD_WIDTH'(ADDR_STATUS))  return SEL_STATUS;
    else if (a == MC_ADD_WIDTH'(ADDR_CTRL))    return SEL_CTRL;
    else if (a == MC_ADD_WIDTH'(ADDR_IRQEN))   return SEL_IRQEN;
    else if (a == MC_ADD_WIDTH'(ADDR_PWM_ON))  return SEL_PWM_ON;
    else if (a == MC_ADD_WIDTH'(ADDR_PWM_OFF)) return SEL_PWM_OFF;
    else                                       return SEL_NONE;
  endfunction

  assign sel    = decodeAddr(mc_add);
  assign wrData = 16'(mc_din);

  // FSM state register
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus single-cycle transaction events. A write commits on the
  // WR exit cycle, so it lands SYNC_STAGES+1 clocks after WE rises at the pin.
  always_comb begin
    state_d     = state_q;
    commitWr    = 1'b0;
    enterRd     = 1'b0;
    exitRd      = 1'b0;
    protoErrEvt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!weSync && !oeSync) begin
          protoErrEvt = 1'b1;
        end else if (!ceSync && !weSync) begin
          state_d = ST_WR;
        end else if (!ceSync && !oeSync) begin
          state_d = ST_RD;
          enterRd = 1'b1;
        end
      end
      ST_WR: begin
        if (weSync || ceSync) begin
          state_d  = ST_IDLE;
          commitWr = 1'b1;
        end
      end
      ST_RD: begin
        if (oeSync || ceSync) begin
          state_d = ST_IDLE;
          exitRd  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read mux; an empty RX FIFO reads as 0
  always_comb begin
    rdValue = 16'h0000;
    case (sel)
      SEL_DATA:    rdValue = rx_nempty ? rx_data : 16'h0000;
      SEL_STATUS:  rdValue = packStatus(tx_full, rx_nempty, spi_busy,
                                        txOvf_q, rxUnf_q, protoErr_q);
      SEL_CTRL:    rdValue = {12'h000, ctrl_q};
`ifdef MC_BRIDGE_IRQ_EN
      SEL_IRQEN:   rdValue = {13'h0000, irqEn_q};
`endif
      SEL_PWM_ON:  rdValue = pwmOn_q;
      SEL_PWM_OFF: rdValue = pwmOff_q;
      default:     rdValue = 16'h0000;
    endcase
  end

  // Sticky error flags: W1C clear is applied first so a same-cycle set wins
  always_comb begin
    txOvf_d    = txOvf_q;
    rxUnf_d    = rxUnf_q;
    protoErr_d = protoErr_q;
    if (commitWr && sel == SEL_STATUS) begin
      if (wrData[STAT_TX_OVF])    txOvf_d    = 1'b0;
      if (wrData[STAT_RX_UNF])    rxUnf_d    = 1'b0;
      if (wrData[STAT_PROTO_ERR]) protoErr_d = 1'b0;
    end
    if (commitWr && sel == SEL_DATA && tx_full) txOvf_d = 1'b1;
    if (enterRd && sel == SEL_DATA && !rx_nempty) rxUnf_d = 1'b1;
    if (protoErrEvt) protoErr_d = 1'b1;
  end

  // Datapath registers. The RX pop decision is frozen at RD entry so the
  // MCU receives exactly the word that is later popped.
  always_ff @(posedge clock) begin
    if (!reset) begin
      txOvf_q      <= 1'b0;
      rxUnf_q      <= 1'b0;
      protoErr_q   <= 1'b0;
      txPush_q     <= 1'b0;
      txData_q     <= 16'h0000;
      rxPop_q      <= 1'b0;
      popPending_q <= 1'b0;
      doe_q        <= 1'b0;
      dout_q       <= '0;
      ctrl_q       <= CTRL_RESET;
      pwmOn_q      <= 16'h0000;
      pwmOff_q     <= 16'h0000;
    end else begin
      txOvf_q    <= txOvf_d;
      rxUnf_q    <= rxUnf_d;
      protoErr_q <= protoErr_d;

      txPush_q <= commitWr && sel == SEL_DATA && !tx_full;
      if (commitWr && sel == SEL_DATA && !tx_full) txData_q <= wrData;
      if (commitWr && sel == SEL_CTRL)    ctrl_q   <= wrData[3:0];
      if (commitWr && sel == SEL_PWM_ON)  pwmOn_q  <= wrData;
      if (commitWr && sel == SEL_PWM_OFF) pwmOff_q <= wrData;

      rxPop_q <= exitRd && popPending_q;
      if (enterRd) begin
        dout_q       <= MC_DATA_WIDTH'(rdValue);
        popPending_q <= (sel == SEL_DATA) && rx_nempty;
      end else if (exitRd) begin
        popPending_q <= 1'b0;
      end

      // Lags the state by one clock: rises the cycle after RD entry and
      // falls the cycle after RD exit
      doe_q <= (state_q == ST_RD);
    end
  end

`ifdef MC_BRIDGE_IRQ_EN
  // Interrupt enables and registered interrupt request
  always_ff @(posedge clock) begin
    if (!reset) begin
      irqEn_q <= 3'b000;
      irq_q   <= 1'b0;
    end else begin
      if (commitWr && sel == SEL_IRQEN) irqEn_q <= wrData[2:0];
      irq_q <= |(irqEn_q & {txOvf_q | rxUnf_q | protoErr_q, ~tx_full, rx_nempty});
    end
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  assign mc_dout    = dout_q;
  assign mc_doe     = doe_q;
  assign tx_push    = txPush_q;
  assign tx_data    = txData_q;
  assign rx_pop     = rxPop_q;
  assign cfg_cpol   = ctrl_q[0];
  assign cfg_cpha   = ctrl_q[1];
  assign cfg_cspol  = ctrl_q[2];
  assign cfg_autocs = ctrl_q[3];
  assign pwm_on     = pwmOn_q;
  assign pwm_off    = pwmOff_q;

endmodule

// File: doc/mc_bridge.md
MC_BRIDGE -- requirements
Module: mc_bridge

Interface
REQ-001 SHALL have parameter MC_DATA_WIDTH, default 16: MCU parallel-bus data width.
REQ-002 SHALL have parameter MC_ADD_WIDTH, default 6: MCU parallel-bus address width.
REQ-003 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on the bus strobes.
REQ-004 Ports:
- clock  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-low reset.
- mc_ce, mc_oe, mc_we  in  1 each  MCU chip enable, output enable and write enable; active-low, asynchronous to clock.
- mc_add  in  MC_ADD_WIDTH  bus address.
- mc_din  in  MC_DATA_WIDTH  bus data from pads.
- mc_dout  out  MC_DATA_WIDTH  bus read data to pads.
- mc_doe  out  1  pad output enable.
- tx_push, tx_data[15:0]  out  push strobe and data into the SPI input FIFO.
- tx_full  in  1  SPI input FIFO full.
- rx_pop  out  1  pop strobe on the SPI output FIFO.
- rx_data[15:0], rx_nempty  in  SPI output FIFO data and not-empty flag.
- spi_busy  in  1  SPI master state.
- cfg_cpol, cfg_cpha, cfg_cspol, cfg_autocs  out  1 each  SPI configuration.
- pwm_on, pwm_off  out  16 each  AUX PWM on/off periods.
- irq  out  1  interrupt request, active-high.

Function
REQ-005 SHALL pass mc_ce, mc_oe and mc_we through SYNC_STAGES flops each before using them.
REQ-006 SHALL implement FSM IDLE, WR, RD.
- IDLE->WR: synced ce=0 and we=0.
- IDLE->RD: synced ce=0 and oe=0.
- Both we and oe low in IDLE: stay in IDLE and set status.proto_err.
REQ-007 WR->IDLE on synced we=1 or ce=1; in that cycle, sample mc_add and mc_din and commit the write.
- MCU SHALL hold address and data for at least SYNC_STAGES+1 clocks after mc_we rises.
REQ-008 RD entry cycle SHALL load mc_dout from the addressed register and assert mc_doe from the next cycle.
- RD->IDLE on synced oe=1 or ce=1.
- mc_doe SHALL drop in the cycle after the exit transition.
REQ-009 Register map:
- 0x00 DATA: a write pushes to tx; a read returns rx_data.
- 0x01 STATUS: read bits [0]tx_full, [1]rx_nempty, [2]spi_busy, [3]tx_ovf, [4]rx_unf, [5]proto_err; writing 1 to bits [5:3] clears them (W1C).
- 0x02 CTRL: bits [3:0] = {autocs, cspol, cpha, cpol}, read/write.
- 0x19 PWM_ON, read/write.
- 0x1A PWM_OFF, read/write.
- Other addresses: writes ignored, reads return 0.
REQ-010 A DATA write SHALL pulse tx_push for exactly one clock with tx_data = mc_din.
- If tx_full=1 at commit: no push, and tx_ovf is set.
REQ-011 A DATA read SHALL pulse rx_pop for one clock on RD exit if rx_nempty was 1 at RD entry.
- If rx_nempty was 0: return 0, no pop, and rx_unf is set.
REQ-012 A W1C clear and a same-cycle set event on the same flag SHALL leave the flag set.
REQ-013 Write commit SHALL occur SYNC_STAGES+1 clocks after the mc_we rising edge at the pin.

Reset
REQ-014 When reset=0 on a clock edge, the block SHALL:
- return to IDLE;
- drive mc_doe=0, mc_dout=0, tx_push=0, rx_pop=0, irq=0;
- clear CTRL to 4'b0110 (cpol=0, cpha=1, cspol=1, autocs=0);
- clear PWM_ON and PWM_OFF to 0, the flags to 0, and the synchronizers to 1.
REQ-015 Reset during WR or RD SHALL discard the transaction, with no push and no pop.

Configuration
REQ-016 With MC_BRIDGE_IRQ_EN defined, register 0x03 IRQEN SHALL exist with bits [0]rx_nempty, [1]tx not full, [2]any error flag.
- irq is registered: OR of enabled sources, one clock latency, reset value 0.
REQ-017 Without MC_BRIDGE_IRQ_EN, irq SHALL be tied 0 and address 0x03 reads 0 and ignores writes.

Structure
REQ-018 A shared package mc_bridge_pkg SHALL hold:
- the register address constants (ADDR_DATA, ADDR_STATUS, ADDR_CTRL, ADDR_IRQEN, ADDR_PWM_ON, ADDR_PWM_OFF);
- the STATUS bit indices;
- the FSM state encoding.
REQ-019 Sub-module mc_sync SHALL be the parameterized SYNC_STAGES flop chain, with reset value 1, instantiated once per strobe.

Verification
REQ-020 Write 0xA5C3 to 0x00 with tx_full=0 -> exactly one tx_push pulse with tx_data=0xA5C3, 3 clocks after mc_we rises.
REQ-021 Write to 0x00 with tx_full=1 -> no tx_push; a read of 0x01 returns bit3=1; writing 0x0008 to 0x01 clears it.
REQ-022 With rx_nempty=1 and rx_data=0x1234, read 0x00 -> mc_dout=0x1234 while mc_doe=1, and one rx_pop after mc_oe rises; repeating with rx_nempty=0 -> 0x0000, no pop, rx_unf=1.
REQ-023 Write 0x0003 to 0x19 and 0x0005 to 0x1A -> pwm_on=3 and pwm_off=5; a read of 0x02 after reset returns 0x0006.
REQ-024 Assert reset mid-write (mc_we low) -> no tx_push, mc_doe=0, FSM in IDLE, CTRL=0x6.
REQ-025 With MC_BRIDGE_IRQ_EN defined, write 0x0001 to 0x03 then raise rx_nempty -> irq=1 one clock later; without the macro, irq stays 0.
